// File: rtl/b_reg_wr_arb.sv
// Write-port arbiter for the single-write-port register file.
// Writeback always wins; queued MDU results come next, and debug writes take the port only when both are quiet.
module b_reg_wr_arb #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              i_sys_clock,
    input  logic              i_sys_reset_n,
    input  logic              i_b_rwa_wb_regwr,
    input  logic [ADDR_W-1:0] i_b_rwa_wb_addr,
    input  logic [DATA_W-1:0] i_b_rwa_wb_data,
    input  logic              i_b_rwa_mdu_valid,
    output logic              o_b_rwa_mdu_ready,
    input  logic [ADDR_W-1:0] i_b_rwa_mdu_addr,
    input  logic [DATA_W-1:0] i_b_rwa_mdu_data,
    input  logic              i_b_rwa_dbg_valid,
    output logic              o_b_rwa_dbg_ready,
    input  logic [ADDR_W-1:0] i_b_rwa_dbg_addr,
    input  logic [DATA_W-1:0] i_b_rwa_dbg_data,
    output logic              o_b_rwa_regwr,
    output logic [ADDR_W-1:0] o_b_rwa_wr_addr,
    output logic [DATA_W-1:0] o_b_rwa_wr_data,
    output logic [31:0]       o_b_rwa_pend_mask,
    output logic              o_b_rwa_stall_req
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0]     fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_valid;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [OCC_W-1:0]      occupancy;
    logic [CNT_W-1:0]      starve_cnt;
    logic [CNT_W-1:0]      starve_cnt_next;
    logic                  stall_q;
    logic [31:0]           pend;

    logic wb_active;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    assign wb_active  = i_b_rwa_wb_regwr && (i_b_rwa_wb_addr != '0);
    assign fifo_empty = (occupancy == '0);
    assign fifo_full  = (occupancy == OCC_W'(FIFO_DEPTH));
    // Results for r0 complete the handshake but are never queued.
    assign push = i_sys_reset_n && i_b_rwa_mdu_valid && !fifo_full && (i_b_rwa_mdu_addr != '0);
    assign pop  = i_sys_reset_n && !wb_active && !fifo_empty;

    always_comb begin
        starve_cnt_next = starve_cnt;
        if (pop || fifo_empty) begin
            starve_cnt_next = '0;
        end else if (wb_active && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_next = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_sys_clock) begin
        if (!i_sys_reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occupancy  <= '0;
            slot_valid <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr             <= rd_ptr + 1'b1;
                slot_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr             <= wr_ptr + 1'b1;
                slot_valid[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
            starve_cnt <= starve_cnt_next;
            if (pop) begin
                stall_q <= 1'b0;
            end else if (starve_cnt_next == CNT_W'(STARVE_LIMIT)) begin
                stall_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_sys_clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_b_rwa_mdu_addr;
            fifo_data[wr_ptr] <= i_b_rwa_mdu_data;
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid[i]) begin
                pend[fifo_addr[i]] = 1'b1;
            end
        end
        pend[0] = 1'b0;
    end

    // Every output is held at zero while reset is asserted.
    always_comb begin
        o_b_rwa_mdu_ready = 1'b0;
        o_b_rwa_dbg_ready = 1'b0;
        o_b_rwa_regwr     = 1'b0;
        o_b_rwa_wr_addr   = '0;
        o_b_rwa_wr_data   = '0;
        o_b_rwa_pend_mask = '0;
        o_b_rwa_stall_req = 1'b0;
        if (i_sys_reset_n) begin
            o_b_rwa_mdu_ready = !fifo_full;
            o_b_rwa_pend_mask = pend;
            o_b_rwa_stall_req = stall_q;
            if (wb_active) begin
                o_b_rwa_regwr   = 1'b1;
                o_b_rwa_wr_addr = i_b_rwa_wb_addr;
                o_b_rwa_wr_data = i_b_rwa_wb_data;
            end else if (!fifo_empty) begin
                o_b_rwa_regwr   = 1'b1;
                o_b_rwa_wr_addr = fifo_addr[rd_ptr];
                o_b_rwa_wr_data = fifo_data[rd_ptr];
            end else if (i_b_rwa_dbg_valid) begin
                o_b_rwa_dbg_ready = 1'b1;
                o_b_rwa_regwr     = (i_b_rwa_dbg_addr != '0);
                o_b_rwa_wr_addr   = i_b_rwa_dbg_addr;
                o_b_rwa_wr_data   = i_b_rwa_dbg_data;
            end
        end
    end

endmodule

// File: tb/tb_b_reg_wr_arb.sv
// Testbench for b_reg_wr_arb: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_b_reg_wr_arb;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_regwr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        regwr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pend_mask;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    logic [4:0]  mq_addr [$];
    logic [31:0] mq_data [$];
    int          m_cnt = 0;
    bit          m_stall = 1'b0;

    logic        e_regwr, e_mdu_ready, e_dbg_ready, e_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_pend;

    always #5 clk = ~clk;

    b_reg_wr_arb dut (
        .i_sys_clock       (clk),
        .i_sys_reset_n     (rst_n),
        .i_b_rwa_wb_regwr  (wb_regwr),
        .i_b_rwa_wb_addr   (wb_addr),
        .i_b_rwa_wb_data   (wb_data),
        .i_b_rwa_mdu_valid (mdu_valid),
        .o_b_rwa_mdu_ready (mdu_ready),
        .i_b_rwa_mdu_addr  (mdu_addr),
        .i_b_rwa_mdu_data  (mdu_data),
        .i_b_rwa_dbg_valid (dbg_valid),
        .o_b_rwa_dbg_ready (dbg_ready),
        .i_b_rwa_dbg_addr  (dbg_addr),
        .i_b_rwa_dbg_data  (dbg_data),
        .o_b_rwa_regwr     (regwr),
        .o_b_rwa_wr_addr   (wr_addr),
        .o_b_rwa_wr_data   (wr_data),
        .o_b_rwa_pend_mask (pend_mask),
        .o_b_rwa_stall_req (stall_req)
    );

    // Expected outputs for the current inputs and queued results.
    function automatic void model_expect();
        bit wb_act = wb_regwr && (wb_addr != 5'd0);
        e_regwr = 0; e_mdu_ready = 0; e_dbg_ready = 0; e_stall = 0;
        e_addr = '0; e_data = '0; e_pend = '0;
        if (!rst_n) return;
        e_mdu_ready = (mq_addr.size() < DEPTH);
        e_stall = m_stall;
        foreach (mq_addr[i]) e_pend = e_pend | (32'd1 << mq_addr[i]);
        e_pend[0] = 1'b0;
        if (wb_act) begin
            e_regwr = 1; e_addr = wb_addr; e_data = wb_data;
        end else if (mq_addr.size() > 0) begin
            e_regwr = 1; e_addr = mq_addr[0]; e_data = mq_data[0];
        end else if (dbg_valid) begin
            e_dbg_ready = 1; e_regwr = (dbg_addr != 5'd0);
            e_addr = dbg_addr; e_data = dbg_data;
        end
    endfunction

    function automatic void model_update();
        bit wb_act, do_pop, do_push;
        if (!rst_n) begin
            mq_addr.delete(); mq_data.delete(); m_cnt = 0; m_stall = 0;
            return;
        end
        wb_act  = wb_regwr && (wb_addr != 5'd0);
        do_pop  = !wb_act && (mq_addr.size() > 0);
        do_push = mdu_valid && (mq_addr.size() < DEPTH) && (mdu_addr != 5'd0);
        if (do_pop || mq_addr.size() == 0) m_cnt = 0;
        else if (wb_act && m_cnt < LIMIT) m_cnt = m_cnt + 1;
        if (do_pop) m_stall = 0;
        else if (m_cnt == LIMIT) m_stall = 1;
        if (do_pop) begin
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
        end
        if (do_push) begin
            mq_addr.push_back(mdu_addr);
            mq_data.push_back(mdu_data);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst_n = 1; wb_regwr = 0; wb_addr = 0; wb_data = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
        dbg_valid = 0; dbg_addr = 0; dbg_data = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; wb_regwr = 1; wb_addr = 5'd3; wb_data = 32'h3333;
        mdu_valid = 1; mdu_addr = 5'd6; mdu_data = 32'h6666;
        dbg_valid = 1; dbg_addr = 5'd2; dbg_data = 32'h2222;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (regwr !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwr: got %0b expected 0", regwr); end
            checks++; if (mdu_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_mdu_ready: got %0b expected 0", mdu_ready); end
            checks++; if (dbg_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbg_ready: got %0b expected 0", dbg_ready); end
            checks++; if (pend_mask !== 32'h0) begin errors++; $display("[TB] FAIL reset_pend: got %h expected 0", pend_mask); end
            checks++; if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall_req); end
            tick();
        end
        set_idle();
        #1;
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_mdu_ready: got %0b expected 1", mdu_ready); end
        checks++; if (regwr !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_regwr: got %0b expected 0", regwr); end
        tick();
    endtask

    task automatic test_mdu_push();
        set_idle();
        mdu_valid = 1; mdu_addr = 5'd5; mdu_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("[TB] FAIL push_ready: got %0b expected 1", mdu_ready); end
        checks++; if (regwr !== 1'b0) begin errors++; $display("[TB] FAIL push_no_bypass: got %0b expected 0", regwr); end
        tick();
        set_idle();
        #1;
        checks++; if (pend_mask !== 32'h20) begin errors++; $display("[TB] FAIL push_pend: got %h expected 00000020", pend_mask); end
        checks++; if (regwr !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL push_write: got %0b/%0d/%h expected 1/5/deadbeef", regwr, wr_addr, wr_data); end
        tick();
        #1;
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("[TB] FAIL push_pend_clear: got %h expected 0", pend_mask); end
        checks++; if (regwr !== 1'b0) begin errors++; $display("[TB] FAIL push_idle: got %0b expected 0", regwr); end
        tick();
    endtask

    task automatic test_full_fifo();
        set_idle();
        wb_regwr = 1; wb_addr = 5'd1; wb_data = 32'h11;
        mdu_valid = 1; mdu_addr = 5'd7; mdu_data = 32'h77;
        #1;
        checks++; if (regwr !== 1'b1 || wr_addr !== 5'd1) begin errors++; $display("[TB] FAIL full_wb1: got %0b/%0d expected 1/1", regwr, wr_addr); end
        tick();
        wb_addr = 5'd2; wb_data = 32'h22; mdu_addr = 5'd8; mdu_data = 32'h88;
        #1;
        checks++; if (mdu_ready !== 1'b1 || pend_mask !== 32'h80) begin errors++; $display("[TB] FAIL full_second_push: got %0b/%h expected 1/00000080", mdu_ready, pend_mask); end
        tick();
        wb_addr = 5'd3; wb_data = 32'h33; mdu_addr = 5'd9; mdu_data = 32'h99;
        #1;
        checks++; if (mdu_ready !== 1'b0 || pend_mask !== 32'h180) begin errors++; $display("[TB] FAIL full_state: got %0b/%h expected 0/00000180", mdu_ready, pend_mask); end
        checks++; if (wr_addr !== 5'd3 || wr_data !== 32'h33) begin errors++; $display("[TB] FAIL full_wb3: got %0d/%h expected 3/33", wr_addr, wr_data); end
        tick();
        wb_addr = 5'd1;
        #1;
        checks++; if (mdu_ready !== 1'b0 || pend_mask !== 32'h180) begin errors++; $display("[TB] FAIL full_hold: got %0b/%h expected 0/00000180", mdu_ready, pend_mask); end
        tick();
        wb_regwr = 0; wb_addr = 0;
        #1;
        checks++; if (regwr !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h77) begin errors++; $display("[TB] FAIL drain_r7: got %0b/%0d/%h expected 1/7/77", regwr, wr_addr, wr_data); end
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("[TB] FAIL drain_ready_registered: got %0b expected 0", mdu_ready); end
        tick();
        #1;
        checks++; if (wr_addr !== 5'd8 || wr_data !== 32'h88 || mdu_ready !== 1'b1 || pend_mask !== 32'h100) begin
            errors++; $display("[TB] FAIL drain_r8: got %0d/%h/%0b/%h expected 8/88/1/00000100", wr_addr, wr_data, mdu_ready, pend_mask); end
        tick();
        mdu_valid = 0;
        #1;
        checks++; if (regwr !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h99 || pend_mask !== 32'h200) begin
            errors++; $display("[TB] FAIL drain_r9: got %0b/%0d/%h/%h expected 1/9/99/00000200", regwr, wr_addr, wr_data, pend_mask); end
        tick();
        #1;
        checks++; if (regwr !== 1'b0 || pend_mask !== 32'h0) begin errors++; $display("[TB] FAIL drain_done: got %0b/%h expected 0/0", regwr, pend_mask); end
        tick();
    endtask

    task automatic test_starvation();
        set_idle();
        mdu_valid = 1; mdu_addr = 5'd10; mdu_data = 32'hA0A0;
        #1;
        tick();
        mdu_valid = 0; wb_regwr = 1; wb_addr = 5'd2; wb_data = 32'h2;
        for (int k = 1; k <= 6; k++) begin
            #1;
            checks++; if (stall_req !== (k >= 5)) begin errors++; $display("[TB] FAIL starve_stall_k%0d: got %0b expected %0b", k, stall_req, (k >= 5)); end
            checks++; if (wr_addr !== 5'd2 || pend_mask !== 32'h400) begin errors++; $display("[TB] FAIL starve_wb_k%0d: got %0d/%h expected 2/00000400", k, wr_addr, pend_mask); end
            tick();
        end
        wb_regwr = 0; wb_addr = 0;
        #1;
        checks++; if (stall_req !== 1'b1 || wr_addr !== 5'd10 || wr_data !== 32'hA0A0) begin
            errors++; $display("[TB] FAIL starve_release: got %0b/%0d/%h expected 1/10/a0a0", stall_req, wr_addr, wr_data); end
        tick();
        #1;
        checks++; if (stall_req !== 1'b0 || pend_mask !== 32'h0) begin errors++; $display("[TB] FAIL starve_clear: got %0b/%h expected 0/0", stall_req, pend_mask); end
        tick();
    endtask

    task automatic test_debug();
        set_idle();
        mdu_valid = 1; mdu_addr = 5'd4; mdu_data = 32'h4444;
        #1;
        tick();
        mdu_valid = 0; dbg_valid = 1; dbg_addr = 5'd3; dbg_data = 32'h1234;
        #1;
        checks++; if (dbg_ready !== 1'b0 || wr_addr !== 5'd4 || wr_data !== 32'h4444) begin
            errors++; $display("[TB] FAIL dbg_wait: got %0b/%0d/%h expected 0/4/4444", dbg_ready, wr_addr, wr_data); end
        tick();
        #1;
        checks++; if (dbg_ready !== 1'b1 || regwr !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h1234) begin
            errors++; $display("[TB] FAIL dbg_grant: got %0b/%0b/%0d/%h expected 1/1/3/1234", dbg_ready, regwr, wr_addr, wr_data); end
        tick();
        dbg_addr = 5'd0; dbg_data = 32'h55;
        #1;
        checks++; if (dbg_ready !== 1'b1 || regwr !== 1'b0) begin errors++; $display("[TB] FAIL dbg_r0: got %0b/%0b expected 1/0", dbg_ready, regwr); end
        tick();
    endtask

    task automatic test_addr_zero();
        set_idle();
        mdu_valid = 1; mdu_addr = 5'd6; mdu_data = 32'h66;
        #1;
        tick();
        wb_regwr = 1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        mdu_addr = 5'd0; mdu_data = 32'h1;
        #1;
        checks++; if (regwr !== 1'b1 || wr_addr !== 5'd6 || wr_data !== 32'h66) begin
            errors++; $display("[TB] FAIL zero_wb_idle: got %0b/%0d/%h expected 1/6/66", regwr, wr_addr, wr_data); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_mdu_ack: got %0b expected 1", mdu_ready); end
        tick();
        mdu_valid = 0;
        #1;
        checks++; if (regwr !== 1'b0 || pend_mask !== 32'h0) begin errors++; $display("[TB] FAIL zero_not_stored: got %0b/%h expected 0/0", regwr, pend_mask); end
        tick();
    endtask

    task automatic test_reset_midop();
        set_idle();
        wb_regwr = 1; wb_addr = 5'd1; mdu_valid = 1; mdu_addr = 5'd12; mdu_data = 32'hC;
        #1;
        tick();
        mdu_addr = 5'd13; mdu_data = 32'hD;
        #1;
        tick();
        mdu_valid = 0;
        #1;
        checks++; if (pend_mask !== 32'h3000) begin errors++; $display("[TB] FAIL midop_pend: got %h expected 00003000", pend_mask); end
        rst_n = 0; mdu_valid = 1; dbg_valid = 1; dbg_addr = 5'd2;
        #1;
        checks++; if (regwr !== 1'b0 || mdu_ready !== 1'b0 || dbg_ready !== 1'b0 || pend_mask !== 32'h0) begin
            errors++; $display("[TB] FAIL midop_reset: got %0b/%0b/%0b/%h expected 0/0/0/0", regwr, mdu_ready, dbg_ready, pend_mask); end
        tick();
        set_idle();
        #1;
        checks++; if (regwr !== 1'b0 || mdu_ready !== 1'b1 || pend_mask !== 32'h0) begin
            errors++; $display("[TB] FAIL midop_discard: got %0b/%0b/%h expected 0/1/0", regwr, mdu_ready, pend_mask); end
        tick();
    endtask

    task automatic test_random();
        bit last_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            wb_regwr  = ($urandom_range(0, 9) < 4);
            wb_addr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data   = $urandom;
            mdu_valid = $urandom_range(0, 1);
            mdu_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mdu_data  = $urandom;
            if (!(dbg_valid && !last_ready)) begin
                dbg_valid = ($urandom_range(0, 2) == 0);
                dbg_addr  = 5'($urandom_range(0, 31));
                dbg_data  = $urandom;
            end
            #1;
            model_expect();
            checks++; if (regwr !== e_regwr) begin errors++; $display("[TB] FAIL rnd_regwr c%0d: got %0b expected %0b", c, regwr, e_regwr); end
            checks++; if (wr_addr !== e_addr) begin errors++; $display("[TB] FAIL rnd_addr c%0d: got %0d expected %0d", c, wr_addr, e_addr); end
            checks++; if (wr_data !== e_data) begin errors++; $display("[TB] FAIL rnd_data c%0d: got %h expected %h", c, wr_data, e_data); end
            checks++; if (mdu_ready !== e_mdu_ready) begin errors++; $display("[TB] FAIL rnd_mdu_ready c%0d: got %0b expected %0b", c, mdu_ready, e_mdu_ready); end
            checks++; if (dbg_ready !== e_dbg_ready) begin errors++; $display("[TB] FAIL rnd_dbg_ready c%0d: got %0b expected %0b", c, dbg_ready, e_dbg_ready); end
            checks++; if (pend_mask !== e_pend) begin errors++; $display("[TB] FAIL rnd_pend c%0d: got %h expected %h", c, pend_mask, e_pend); end
            checks++; if (stall_req !== e_stall) begin errors++; $display("[TB] FAIL rnd_stall c%0d: got %0b expected %0b", c, stall_req, e_stall); end
            last_ready = e_dbg_ready;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_mdu_push();
        test_full_fifo();
        test_starvation();
        test_debug();
        test_addr_zero();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/b_reg_wr_arb.md
Name: b_reg_wr_arb

Overview:
Write-port arbiter and scheduler for the 32x32 register file, which has one write port. It shares that port between three sources: the pipeline writeback stage, the multi-cycle multiply/divide unit (MDU) and the debug write port. MDU results queue in a small FIFO until the port is free. The block also exports a pending-write mask for the hazard unit and a stall request when queued MDU results are starved.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
FIFO_DEPTH, 2, MDU result queue depth (power of two, >=2)
STARVE_LIMIT, 4, consecutive blocked cycles before stall request
CNT_W, 3, starvation counter width (must hold STARVE_LIMIT)

Ports:
i_sys_clock  in  1  system clock; all state updates on posedge
i_sys_reset_n  in  1  synchronous active-low reset
i_b_rwa_wb_regwr  in  1  writeback write enable
i_b_rwa_wb_addr  in  ADDR_W  writeback destination
i_b_rwa_wb_data  in  DATA_W  writeback data
i_b_rwa_mdu_valid  in  1  MDU result valid
o_b_rwa_mdu_ready  out  1  MDU result accepted
i_b_rwa_mdu_addr  in  ADDR_W  MDU destination
i_b_rwa_mdu_data  in  DATA_W  MDU result
i_b_rwa_dbg_valid  in  1  debug write request
o_b_rwa_dbg_ready  out  1  debug write granted
i_b_rwa_dbg_addr  in  ADDR_W  debug destination
i_b_rwa_dbg_data  in  DATA_W  debug data
o_b_rwa_regwr  out  1  register file write enable
o_b_rwa_wr_addr  out  ADDR_W  register file write address
o_b_rwa_wr_data  out  DATA_W  register file write data
o_b_rwa_pend_mask  out  32  bit n = queued MDU write to register n
o_b_rwa_stall_req  out  1  request to bubble writeback

Behaviour:
- Reset (i_sys_reset_n=0 at posedge): FIFO emptied and its contents discarded, including mid-operation. Starvation counter=0, stall_req=0. While reset is low, all outputs are forced to 0, including regwr, both readies and pend_mask.
- WB active = wb_regwr && wb_addr!=0. A WB request with address 0 is treated as idle.
- Grant priority, combinational, same cycle:
  1. WB active: WB drives the port.
  2. Otherwise, FIFO not empty: the FIFO head drives the port and pops at the posedge.
  3. Otherwise, dbg_valid: debug drives the port.
- WB cannot be stalled by this block; it always wins.
- Write outputs: regwr=1 only for a granted non-zero address. addr and data are muxed from the granted source and are 0 when there is no grant.
- MDU handshake:
  - mdu_ready = !full, registered state only, no dependence on mdu_valid or on a same-cycle pop.
  - Transfer on valid&&ready at the posedge.
  - An entry with addr 0 is acknowledged but not stored.
  - There is no bypass: the earliest register-file write is the cycle after acceptance.
  - Push and pop in the same cycle are legal when the FIFO is not full; occupancy is unchanged.
- FIFO: in-order, pointers wrap modulo FIFO_DEPTH, occupancy counter 0..FIFO_DEPTH.
- Debug handshake:
  - dbg_ready = dbg_valid && !WB active && FIFO empty, combinational.
  - A grant with dbg_addr 0 completes with no write.
  - The debug source holds valid/addr/data until ready.
- pend_mask: OR of one-hot decodes of all valid FIFO entries, combinational from FIFO state. Bit 0 is always 0. The bit clears in the cycle after the pop.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and WB active blocks it.
  - Clears on any pop, and holds at 0 when the FIFO is empty.
- stall_req is registered:
  - Set at the posedge where the counter's next value equals STARVE_LIMIT.
  - Cleared at the posedge of a pop.
  - While stall_req=1 and WB is still active, WB still wins and the counter stays saturated.
- Simultaneous WB, MDU and debug: WB writes, MDU pushes if not full, debug waits.

Test Plan:
1. Reset: hold i_sys_reset_n=0 for 2 cycles with all valids high -> regwr=0, mdu_ready=0, dbg_ready=0, pend_mask=0, stall_req=0. After release: mdu_ready=1.
2. MDU push with WB idle: mdu (addr 5, 0xDEAD_BEEF) accepted at cycle t -> pend_mask=0x20 at t+1. At t+1: regwr=1, addr=5, data=0xDEAD_BEEF. At t+2: pend_mask=0.
3. Full FIFO: WB writes r1..r3 continuously while MDU pushes r7 and r8 -> after 2 pushes mdu_ready=0 and pend_mask=0x180. Third result (r9) is held until a pop. Entries drain in order r7, r8, r9 once WB goes idle.
4. Starvation with STARVE_LIMIT=4: FIFO holds r10 and WB is active for 6 cycles -> stall_req rises after the 4th blocked cycle. When WB drops, r10 is written and stall_req=0 on the next cycle.
5. Debug lowest priority: dbg (r3, 0x1234) while FIFO holds r4 -> r4 written first, dbg_ready=1 the following cycle, then r3=0x1234. Debug to r0 -> dbg_ready=1, regwr=0.
6. Address zero: WB regwr=1 to r0 with FIFO non-empty -> the FIFO head is written that cycle. MDU push to r0 is acknowledged, pend_mask unchanged, and no write occurs.
